// File: rtl/parity_defs.sv
// Shared parity-mode encoding for the stream checker and the parity generator.
package parity_defs;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_mode_e;

endpackage

// File: rtl/parity_lane.sv
// Single-lane combinational parity check: flags a word whose data+parity
// population does not match the selected odd/even mode.
module parity_lane
    import parity_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             parity,
    input  logic             odd,
    output logic             error
);

    logic xor_all;

    always_comb begin
        xor_all = ^{data, parity};
        error   = (odd == PARITY_ODD) ? ~xor_all : xor_all;
    end

endmodule

// File: rtl/parity_stream_checker.sv
// Multi-lane registered parity checker with sticky per-lane flags and a
// saturating lane-error counter.
module parity_stream_checker
    import parity_defs::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_x,
    input  logic                   i_valid,
    input  logic [LANES*WIDTH-1:0] i_data,
    input  logic [LANES-1:0]       i_parity,
    input  logic                   i_odd,
    input  logic                   i_clear,
    output logic                   o_valid,
    output logic [LANES-1:0]       o_error_lanes,
    output logic                   o_error,
    output logic [LANES-1:0]       o_sticky,
    output logic [CNT_WIDTH-1:0]   o_count
);

    logic [LANES-1:0]     lane_err;
    logic [LANES-1:0]     beat_err;
    logic [CNT_WIDTH:0]   err_cnt;
    logic [CNT_WIDTH:0]   cnt_base;
    logic [CNT_WIDTH:0]   cnt_sum;
    logic [CNT_WIDTH-1:0] count_next;
    logic [LANES-1:0]     sticky_next;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        parity_lane #(.WIDTH(WIDTH)) u_lane (
            .data   (i_data[k*WIDTH +: WIDTH]),
            .parity (i_parity[k]),
            .odd    (i_odd),
            .error  (lane_err[k])
        );
    end

    // Clear is applied before this beat's contribution so a colliding
    // erroring beat is still recorded.
    always_comb begin
        beat_err = i_valid ? lane_err : '0;
        err_cnt  = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            err_cnt = err_cnt + (CNT_WIDTH+1)'(beat_err[k]);
        end
        cnt_base    = i_clear ? '0 : {1'b0, o_count};
        cnt_sum     = cnt_base + err_cnt;
        count_next  = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        sticky_next = (i_clear ? '0 : o_sticky) | beat_err;
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            o_valid       <= 1'b0;
            o_error_lanes <= '0;
            o_sticky      <= '0;
            o_count       <= '0;
        end else begin
            o_valid       <= i_valid;
            o_error_lanes <= beat_err;
            o_sticky      <= sticky_next;
            o_count       <= count_next;
        end
    end

    assign o_error = |o_error_lanes;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed and randomized bench for parity_stream_checker against a
// population-count reference model.
module tb_parity_stream_checker;

    localparam int W        = 8;
    localparam int L        = 4;
    localparam int CW       = 4;
    localparam int CNT_MAX  = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst_x;
    logic           i_valid;
    logic [L*W-1:0] i_data;
    logic [L-1:0]   i_parity;
    logic           i_odd;
    logic           i_clear;
    logic           o_valid;
    logic [L-1:0]   o_error_lanes;
    logic           o_error;
    logic [L-1:0]   o_sticky;
    logic [CW-1:0]  o_count;

    int tests = 0;
    int fails = 0;

    logic         m_valid;
    logic [L-1:0] m_lanes;
    logic [L-1:0] m_sticky;
    int           m_count;

    parity_stream_checker #(.WIDTH(W), .LANES(L), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_x         (rst_x),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_parity      (i_parity),
        .i_odd         (i_odd),
        .i_clear       (i_clear),
        .o_valid       (o_valid),
        .o_error_lanes (o_error_lanes),
        .o_error       (o_error),
        .o_sticky      (o_sticky),
        .o_count       (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"},  32'(o_valid),       32'(m_valid));
        chk({tag, "_lanes"},  32'(o_error_lanes), 32'(m_lanes));
        chk({tag, "_error"},  32'(o_error),       32'(|m_lanes));
        chk({tag, "_sticky"}, 32'(o_sticky),      32'(m_sticky));
        chk({tag, "_count"},  32'(o_count),       32'(m_count));
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_lanes  = '0;
        m_sticky = '0;
        m_count  = 0;
    endtask

    // A lane is wrong when its total ones (data + parity + mode bit) is odd.
    function automatic logic [L-1:0] ref_errors(input logic [L*W-1:0] d, input logic [L-1:0] p,
                                                input logic odd);
        logic [L-1:0] e;
        for (int k = 0; k < L; k++) begin
            logic [W-1:0] word;
            word = d[k*W +: W];
            e[k] = ((int'($countones(word)) + int'(p[k]) + int'(odd)) % 2) == 1;
        end
        return e;
    endfunction

    task automatic step(input logic v, input logic [L*W-1:0] d, input logic [L-1:0] p,
                        input logic odd, input logic clr, input string tag);
        logic [L-1:0] e;
        i_valid  = v;
        i_data   = d;
        i_parity = p;
        i_odd    = odd;
        i_clear  = clr;
        @(posedge clk);
        #1;
        e = ref_errors(d, p, odd);
        if (clr) begin
            m_sticky = '0;
            m_count  = 0;
        end
        if (v) begin
            m_lanes  = e;
            m_sticky = m_sticky | e;
            m_count  = m_count + $countones(e);
            if (m_count > CNT_MAX) m_count = CNT_MAX;
        end else begin
            m_lanes = '0;
        end
        m_valid = v;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_x = 1'b0;
        #1;
        model_reset();
        check_all({tag, "_immediate"});
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        rst_x = 1'b1;
    endtask

    localparam logic [31:0] DATA = 32'h0703_0100;

    initial begin
        model_reset();
        rst_x    = 1'b0;
        i_valid  = 1'b1;
        i_data   = $urandom;
        i_parity = 4'($urandom);
        i_odd    = 1'($urandom);
        i_clear  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all("reset");
            i_data = $urandom;
        end
        rst_x = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, $urandom, 4'($urandom), 1'b1, 1'b0, "idle");

        step(1'b1, DATA, 4'b0101, 1'b1, 1'b0, "odd_ok");
        chk("odd_ok_lit", 32'(o_error_lanes), 32'h0);
        step(1'b1, DATA, 4'b0001, 1'b1, 1'b0, "odd_flip2");
        chk("odd_flip2_lanes_lit", 32'(o_error_lanes), 32'h4);
        chk("odd_flip2_count_lit", 32'(o_count), 32'd1);
        chk("odd_flip2_sticky_lit", 32'(o_sticky), 32'h4);
        step(1'b1, DATA, 4'b1010, 1'b0, 1'b0, "even_ok");
        chk("even_ok_lit", 32'(o_error_lanes), 32'h0);
        step(1'b1, DATA, 4'b0101, 1'b0, 1'b0, "even_all");
        chk("even_all_lanes_lit", 32'(o_error_lanes), 32'hF);
        chk("even_all_count_lit", 32'(o_count), 32'd5);

        step(1'b0, DATA, 4'b0101, 1'b1, 1'b1, "clear_alone");
        chk("clear_alone_count_lit", 32'(o_count), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, DATA, 4'b1010, 1'b1, 1'b0, "sat");
        chk("sat_count_lit", 32'(o_count), 32'd15);

        step(1'b0, DATA, 4'b0101, 1'b1, 1'b1, "clear2");
        for (int i = 0; i < 5; i++) step(1'b1, DATA, 4'b1101, 1'b1, 1'b0, "lane3");
        chk("lane3_count_lit", 32'(o_count), 32'd5);
        step(1'b1, DATA, 4'b0100, 1'b1, 1'b1, "collide");
        chk("collide_count_lit", 32'(o_count), 32'd1);
        chk("collide_sticky_lit", 32'(o_sticky), 32'h1);

        step(1'b1, DATA, 4'b1111, 1'b1, 1'b0, "gap_a");
        step(1'b0, DATA, 4'b1111, 1'b1, 1'b0, "gap_b");
        chk("gap_b_lanes_lit", 32'(o_error_lanes), 32'h0);
        step(1'b1, DATA, 4'b1111, 1'b1, 1'b0, "gap_c");
        async_reset("areset");
        step(1'b1, DATA, 4'b1111, 1'b1, 1'b0, "post_reset");

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom), 1'($urandom),
                 1'($urandom_range(0, 19) == 0), "rand");
            if ($urandom_range(0, 59) == 0) async_reset("rand_areset");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
